// File: rtl/riscv_pkg.sv
// Shared encodings for the integer pipeline: result-select codes, load funct3 values
// and the datapath width.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_ZERO = 2'b11
  } resultSrcE;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of an aligned memory word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = 8'h00;
    case (off)
      2'd0: byteSel = word[7:0];
      2'd1: byteSel = word[15:8];
      2'd2: byteSel = word[23:16];
      2'd3: byteSel = word[31:24];
      default: byteSel = 8'h00;
    endcase
    halfSel = off[1] ? word[31:16] : word[15:0];
  end

  // Unrecognised funct3 encodings fall back to a full-word load.
  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byteSel[7]}}, byteSel};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byteSel};
      F3_LH:   value = {{(XLEN-16){halfSel[15]}}, halfSel};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, halfSel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register-file write driver, forwarding bus and
// per-register pending-write scoreboard used by decode for RAW hazard detection.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int SB_CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regWrite,
  input  logic [1:0]      mem_resultSrc,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_aluResult,
  input  logic [XLEN-1:0] mem_loadData,
  input  logic [XLEN-1:0] mem_pcPlus4,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_regWrite,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1Busy,
  output logic            rs2Busy,
  output logic [4:0]      rd,
  output logic            writeEnable,
  output logic [XLEN-1:0] writeData,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            sbOverflow
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = {SB_CNT_W{1'b1}};

  logic            wbValid;
  logic [4:0]      wbRd;
  logic            wbRegWrite;
  logic [1:0]      wbResultSrc;
  logic [2:0]      wbFunct3;
  logic [XLEN-1:0] wbAluResult;
  logic [XLEN-1:0] wbLoadData;
  logic [XLEN-1:0] wbPcPlus4;

  logic [XLEN-1:0] loadValue;
  logic [XLEN-1:0] result;
  logic            commit;
  logic            inc;
  logic [31:0]     incVec;
  logic [31:0]     decVec;

  logic [SB_CNT_W-1:0] cnt [32];

  assign mem_ready = !stall;

  // Payload is cleared on reset so rd/writeData read as zero until the first capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbValid     <= 1'b0;
      wbRd        <= '0;
      wbRegWrite  <= 1'b0;
      wbResultSrc <= '0;
      wbFunct3    <= '0;
      wbAluResult <= '0;
      wbLoadData  <= '0;
      wbPcPlus4   <= '0;
    end else if (mem_ready) begin
      wbValid <= mem_valid;
      if (mem_valid) begin
        wbRd        <= mem_rd;
        wbRegWrite  <= mem_regWrite;
        wbResultSrc <= mem_resultSrc;
        wbFunct3    <= mem_funct3;
        wbAluResult <= mem_aluResult;
        wbLoadData  <= mem_loadData;
        wbPcPlus4   <= mem_pcPlus4;
      end
    end
  end

  load_extend uLoadExtend (
    .funct3 (wbFunct3),
    .off    (wbAluResult[1:0]),
    .word   (wbLoadData),
    .value  (loadValue)
  );

  always_comb begin
    result = wbAluResult;
    case (wbResultSrc)
      RESULT_ALU:  result = wbAluResult;
      RESULT_LOAD: result = loadValue;
      RESULT_PC4:  result = wbPcPlus4;
      RESULT_ZERO: result = '0;
      default:     result = wbAluResult;
    endcase
  end

  assign commit      = wbValid && !stall;
  assign writeEnable = commit && wbRegWrite && (wbRd != 5'd0);
  assign rd          = wbRd;
  assign writeData   = result;
  assign fwd_valid   = writeEnable;
  assign fwd_rd      = rd;
  assign fwd_data    = writeData;

  assign inc = issue_valid && issue_regWrite && (issue_rd != 5'd0);

  always_comb begin
    incVec = '0;
    decVec = '0;
    if (inc)         incVec[issue_rd] = 1'b1;
    if (writeEnable) decVec[wbRd]     = 1'b1;
  end

  // Entry 0 is only ever reset, so x0 never reports busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbOverflow <= 1'b0;
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (incVec[i] && !decVec[i]) begin
          if (cnt[i] == CNT_MAX) sbOverflow <= 1'b1;
          else                   cnt[i] <= cnt[i] + 1'b1;
        end else if (decVec[i] && !incVec[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign rs1Busy = (cnt[rs1] != '0);
  assign rs2Busy = (cnt[rs2] != '0);

endmodule
